// File: rtl/nrzi_pkg.sv
// ============================================================================
// Module  : nrzi_pkg
// Brief   : Shared types and default constants for the NRZI transmit path.
//           Optional feature macro: BIT_STUFF_EN (enables bit stuffing).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nrzi_pkg;

    // Line controller states; the encoding is fixed at 3 bits
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_STUFF = 3'd3,
        ST_EOP   = 3'd4
    } state_t;

    // Sync byte, sent LSB-first as 0,0,0,0,0,0,0,1
    localparam logic [7:0] SYNC_PATTERN_DEF = 8'h80;
    // Number of end-of-packet bit periods (line held at NRZ 1)
    localparam int         EOP_BITS_DEF     = 2;
    // Consecutive NRZ ones that force an inserted 0
    localparam int         STUFF_LIMIT_DEF  = 6;

endpackage

`default_nettype wire

// File: rtl/nrzi_tx_ctrl_if.sv
// ============================================================================
// Module  : nrzi_tx_ctrl_if
// Brief   : Byte valid/ready handshake between the packet source and the
//           NRZI line controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface nrzi_tx_ctrl_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;

    modport master (output in_data, output in_valid, output in_last, input  in_ready);
    modport slave  (input  in_data, input  in_valid, input  in_last, output in_ready);
endinterface

`default_nettype wire

// File: rtl/nrzi_enc.sv
// ============================================================================
// Module  : nrzi_enc
// Brief   : Registered NRZ to NRZI encoder. The output toggles on every
//           input 1 and holds on 0; one cycle of latency.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nrzi_enc (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic out_o
);

    logic out_q;

    // Line level: flips on a 1, holds on a 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else if (in_i) begin
            out_q <= ~out_q;
        end
    end

    assign out_o = out_q;

endmodule

`default_nettype wire

// File: rtl/nrzi_tx_ctrl.sv
// ============================================================================
// Module  : nrzi_tx_ctrl
// Brief   : NRZI transmit line controller. Frames accepted bytes as
//           SYNC + LSB-first data + EOP, optionally bit-stuffs, and drives
//           the NRZ stream into a registered NRZI encoder.
//           Optional feature macro: BIT_STUFF_EN (insert a 0 after
//           STUFF_LIMIT consecutive ones in SYNC/DATA).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nrzi_tx_ctrl
    import nrzi_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
    parameter int         EOP_BITS     = EOP_BITS_DEF
`ifdef BIT_STUFF_EN
    ,
    parameter int         STUFF_LIMIT  = STUFF_LIMIT_DEF
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    nrzi_tx_ctrl_if.slave  bus,
    output logic           nrz_bit_o,
    output logic           nrzi_out_o,
    output logic           tx_active_o,
    output logic           underrun_o
);

    localparam int EOP_W = (EOP_BITS > 1) ? $clog2(EOP_BITS) : 1;

    // state_q / idx_q describe the bit currently held in nrz_q on the line
    state_t             state_q,   state_d;
    logic [2:0]         idx_q,     idx_d;
    logic [7:0]         shreg_q,   shreg_d;
    logic               last_q,    last_d;
    logic [EOP_W-1:0]   eop_cnt_q, eop_cnt_d;
    logic               nrz_q,     nrz_d;

    logic               w_ready;
    logic               w_underrun;
    logic               w_stuff_now;

`ifdef BIT_STUFF_EN
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    logic [ONES_W-1:0]  ones_q,     ones_d;
    logic               eop_pend_q, eop_pend_d;
    logic [ONES_W-1:0]  w_ones_now;

    // Run length of ones including the bit now on the line; only SYNC and
    // DATA bits count, so STUFF, EOP and IDLE all restart the run at zero
    always_comb begin
        w_ones_now  = '0;
        if ((state_q == ST_SYNC || state_q == ST_DATA) && nrz_q) begin
            w_ones_now = ones_q + ONES_W'(1);
        end
        w_stuff_now = (w_ones_now == ONES_W'(STUFF_LIMIT));
        ones_d      = w_stuff_now ? '0 : w_ones_now;
    end
`else
    assign w_stuff_now = 1'b0;
`endif

    // Next-state, next line bit and handshake decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        last_d     = last_q;
        eop_cnt_d  = eop_cnt_q;
        nrz_d      = 1'b0;
        w_ready    = 1'b0;
        w_underrun = 1'b0;
`ifdef BIT_STUFF_EN
        eop_pend_d = eop_pend_q;
`endif

        case (state_q)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = ST_SYNC;
                    idx_d   = 3'd0;
                    shreg_d = bus.in_data;
                    last_d  = bus.in_last;
                    nrz_d   = SYNC_PATTERN[0];
                end
            end

            ST_SYNC: begin
                if (idx_q != 3'd7) begin
                    idx_d = idx_q + 3'd1;
                    nrz_d = SYNC_PATTERN[idx_d];
                end else begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    nrz_d   = shreg_q[0];
                end
            end

            ST_DATA: begin
                if (idx_q != 3'd7) begin
                    idx_d = idx_q + 3'd1;
                    nrz_d = shreg_q[idx_d];
                end else if (last_q) begin
                    state_d   = ST_EOP;
                    eop_cnt_d = '0;
                    nrz_d     = 1'b1;
                end else begin
                    // Next byte is fetched during bit 7 so it follows with no gap
                    w_ready = 1'b1;
                    if (bus.in_valid) begin
                        idx_d   = 3'd0;
                        shreg_d = bus.in_data;
                        last_d  = bus.in_last;
                        nrz_d   = bus.in_data[0];
                    end else begin
                        w_underrun = 1'b1;
                        state_d    = ST_EOP;
                        eop_cnt_d  = '0;
                        nrz_d      = 1'b1;
                    end
                end
            end

`ifdef BIT_STUFF_EN
            ST_STUFF: begin
                // idx/shreg were already advanced when the stuff bit was taken
                if (eop_pend_q) begin
                    state_d   = ST_EOP;
                    eop_cnt_d = '0;
                    nrz_d     = 1'b1;
                end else begin
                    state_d = ST_DATA;
                    nrz_d   = shreg_q[idx_q];
                end
            end
`endif

            ST_EOP: begin
                if (eop_cnt_q == EOP_W'(EOP_BITS - 1)) begin
                    state_d = ST_IDLE;
                    nrz_d   = 1'b0;
                end else begin
                    eop_cnt_d = eop_cnt_q + EOP_W'(1);
                    nrz_d     = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef BIT_STUFF_EN
        // A pending stuff bit pre-empts whatever was decoded above; the
        // decoded destination is remembered and resumed after the 0
        if (w_stuff_now) begin
            eop_pend_d = (state_d == ST_EOP);
            state_d    = ST_STUFF;
            nrz_d      = 1'b0;
        end
`endif
    end

    // State, datapath and line-bit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            shreg_q   <= 8'd0;
            last_q    <= 1'b0;
            eop_cnt_q <= '0;
            nrz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            last_q    <= last_d;
            eop_cnt_q <= eop_cnt_d;
            nrz_q     <= nrz_d;
        end
    end

`ifdef BIT_STUFF_EN
    // Ones run length and the deferred-EOP flag for the stuff bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q     <= '0;
            eop_pend_q <= 1'b0;
        end else begin
            ones_q     <= ones_d;
            eop_pend_q <= eop_pend_d;
        end
    end
`endif

    nrzi_enc u_enc (
        .clk   (clk),
        .rst_n (rst_n),
        .in_i  (nrz_q),
        .out_o (nrzi_out_o)
    );

    // Ready is forced low while reset is held, even though the FSM sits in IDLE
    assign bus.in_ready = w_ready & rst_n;
    assign nrz_bit_o    = nrz_q;
    assign tx_active_o  = (state_q != ST_IDLE);
    assign underrun_o   = w_underrun;

endmodule

`default_nettype wire

// File: tb/tb_nrzi_tx_ctrl.sv
// ============================================================================
// Module  : tb_nrzi_tx_ctrl
// Brief   : Self-checking bench for nrzi_tx_ctrl. Expected line streams are
//           built as bit lists from the framing rules (sync, LSB-first data,
//           stuffing by run length, EOP). Honours BIT_STUFF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nrzi_tx_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic nrz_bit, nrzi_out, tx_active, underrun;

    nrzi_tx_ctrl_if bus ();

    nrzi_tx_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .nrz_bit_o   (nrz_bit),
        .nrzi_out_o  (nrzi_out),
        .tx_active_o (tx_active),
        .underrun_o  (underrun)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic nrzi_exp;

    logic [7:0] fb[$];        // bytes of the frame under test
    bit         exp_bits[$];  // expected NRZ stream while tx_active
    bit         exp_rdy[$];   // expected in_ready per stream position
    bit         cap[$];       // captured NRZ stream
    int         upos;         // stream position of the expected underrun pulse
    int         m_len, m_ones, m_und;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        int         n;
        bit         und;
        int         len_stuff;
        int         len_plain;
        int         ones;
    } vec_t;

    vec_t tbl[6];

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Append one SYNC/DATA bit and apply the stuffing rule on its run length
    task automatic push_bit(input bit v, input bit rdy, inout int ones);
        exp_bits.push_back(v);
        exp_rdy.push_back(rdy);
        ones = v ? ones + 1 : 0;
`ifdef BIT_STUFF_EN
        if (ones == 6) begin
            exp_bits.push_back(1'b0);
            exp_rdy.push_back(1'b0);
            ones = 0;
        end
`endif
    endtask

    // Expected stream for the bytes in fb; und means the source stops early
    task automatic build_model(input bit und);
        int         ones = 0;
        int         n    = fb.size();
        logic [7:0] sync = 8'h80;
        logic [7:0] b;
        exp_bits.delete();
        exp_rdy.delete();
        upos = -100;
        for (int i = 0; i < 8; i++) push_bit(sync[i], 1'b0, ones);
        for (int k = 0; k < n; k++) begin
            b = fb[k];
            for (int i = 0; i < 8; i++) begin
                if (und && k == n - 1 && i == 7) upos = exp_bits.size();
                push_bit(b[i], (i == 7) && !(k == n - 1 && !und), ones);
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_bits.push_back(1'b1);
            exp_rdy.push_back(1'b0);
        end
    endtask

    // Drive one frame from fb and check every cycle against the model.
    // Must be entered just after a rising edge.
    task automatic run_frame(input int pre_idle, input bit und);
        int   n = fb.size();
        int   L;
        int   bi = 0;
        int   p;
        bit   fire;
        logic e_nrz, e_tx, e_rdy, e_und;
        build_model(und);
        L = exp_bits.size();
        m_len = 0; m_ones = 0; m_und = 0;
        cap.delete();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (pre_idle) begin
            @(negedge clk);
            chk1("idle_tx_active", tx_active, 1'b0);
            chk1("idle_in_ready", bus.in_ready, 1'b1);
            chk1("idle_nrzi", nrzi_out, nrzi_exp);
            @(posedge clk); #1;
        end
        bus.in_data  = fb[0];
        bus.in_valid = 1'b1;
        bus.in_last  = !und && (n == 1);
        for (int cyc = 0; cyc < L + 2; cyc++) begin
            @(negedge clk);
            p     = cyc - 1;
            e_tx  = (p >= 0 && p < L);
            e_nrz = e_tx ? exp_bits[p] : 1'b0;
            e_rdy = e_tx ? exp_rdy[p] : 1'b1;
            e_und = (p == upos);
            chk1("nrz_bit", nrz_bit, e_nrz);
            chk1("tx_active", tx_active, e_tx);
            chk1("in_ready", bus.in_ready, e_rdy);
            chk1("underrun", underrun, e_und);
            chk1("nrzi_out", nrzi_out, nrzi_exp);
            nrzi_exp = nrzi_exp ^ e_nrz;
            if (tx_active) begin
                m_len++;
                cap.push_back(nrz_bit);
                if (nrz_bit) m_ones++;
            end
            if (underrun) m_und++;
            fire = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (fire) begin
                bi++;
                if (bi < n) begin
                    bus.in_data = fb[bi];
                    bus.in_last = !und && (bi == n - 1);
                end else begin
                    bus.in_valid = 1'b0;
                    bus.in_last  = 1'b0;
                end
            end
        end
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] pack_cap();
        logic [31:0] v = '0;
        foreach (cap[i]) v = {v[30:0], cap[i]};
        return v;
    endfunction

    initial begin
        logic [31:0] a5_seq;
        logic [31:0] ff_seq;
        int          exp_len;
        bit          und;
        int          n;

        tbl[0] = '{8'hA5, 8'h00, 1, 1'b0, 18, 18, 7};
        tbl[1] = '{8'hFF, 8'h00, 1, 1'b0, 19, 18, 11};
        tbl[2] = '{8'h12, 8'h34, 2, 1'b0, 26, 26, 8};
        tbl[3] = '{8'h5A, 8'h00, 1, 1'b1, 18, 18, 7};
        tbl[4] = '{8'h00, 8'h00, 1, 1'b0, 18, 18, 3};
        tbl[5] = '{8'h7E, 8'h00, 1, 1'b0, 19, 18, 9};

        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        nrzi_exp     = 1'b0;
        rst_n        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_in_ready", bus.in_ready, 1'b0);
        chk1("rst_nrz_bit", nrz_bit, 1'b0);
        chk1("rst_nrzi_out", nrzi_out, 1'b0);
        chk1("rst_tx_active", tx_active, 1'b0);
        chk1("rst_underrun", underrun, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk1("post_rst_in_ready", bus.in_ready, 1'b1);

        // Table-driven frames: length, ones count and underrun pulse count
        for (int k = 0; k < 6; k++) begin
            fb.delete();
            fb.push_back(tbl[k].b0);
            if (tbl[k].n > 1) fb.push_back(tbl[k].b1);
            run_frame(1, tbl[k].und);
`ifdef BIT_STUFF_EN
            exp_len = tbl[k].len_stuff;
`else
            exp_len = tbl[k].len_plain;
`endif
            chkn($sformatf("tbl%0d_len", k), m_len, exp_len);
            chkn($sformatf("tbl%0d_ones", k), m_ones, tbl[k].ones);
            chkn($sformatf("tbl%0d_underruns", k), m_und, tbl[k].und ? 1 : 0);
        end

        // Exact stream of a single 0xA5 frame
        a5_seq = 32'b000000011010010111;
        fb.delete();
        fb.push_back(8'hA5);
        run_frame(0, 1'b0);
        chkn("a5_len", m_len, 18);
        chkn("a5_stream", int'(pack_cap()), int'(a5_seq));

        // Exact stream of a single 0xFF frame
`ifdef BIT_STUFF_EN
        ff_seq = 32'b0000000111111011111;
`else
        ff_seq = 32'b000000011111111111;
`endif
        fb.delete();
        fb.push_back(8'hFF);
        run_frame(0, 1'b0);
        chkn("ff_stream", int'(pack_cap()), int'(ff_seq));

        // Asynchronous reset during DATA bit 3 of a 0xFF byte
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        bus.in_last  = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        chk1("pre_rst_tx_active", tx_active, 1'b1);
        chk1("pre_rst_nrz_bit", nrz_bit, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_nrz_bit", nrz_bit, 1'b0);
        chk1("mid_rst_nrzi_out", nrzi_out, 1'b0);
        chk1("mid_rst_tx_active", tx_active, 1'b0);
        chk1("mid_rst_underrun", underrun, 1'b0);
        chk1("mid_rst_in_ready", bus.in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        nrzi_exp = 1'b0;
        @(posedge clk); #1;
        fb.delete();
        fb.push_back(8'h00);
        run_frame(1, 1'b0);
        chkn("after_rst_len", m_len, 18);
        fb.delete();
        fb.push_back(8'hFF);
        run_frame(0, 1'b0);
        chkn("after_rst_ff_stream", int'(pack_cap()), int'(ff_seq));

        // Randomised frames against the stream model
        for (int r = 0; r < 40; r++) begin
            fb.delete();
            n   = $urandom_range(1, 3);
            und = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < n; k++) begin
                fb.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
            end
            run_frame($urandom_range(0, 3), und);
            chkn("rand_len", m_len, exp_bits.size());
            chkn("rand_underruns", m_und, und ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
